// File: rtl/redmule_x_buffer_mq.sv
// Multi-slot X-operand tile queue for the RedMulE array: packs streamed rows into D tiles and
// reveals the head tile column by column. Leftover masking is built when REDMULE_XBUF_LFTOVR_EN is defined.
module redmule_x_buffer_mq #(
    parameter int unsigned DW   = 288,
    parameter int unsigned BITW = 16,
    parameter int unsigned H    = 4,
    parameter int unsigned W    = 12,
    parameter int unsigned D    = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             clear_i,
    input  logic                             x_valid_i,
    output logic                             x_ready_o,
    input  logic [DW-1:0]                    x_i,
    input  logic [$clog2(W):0]               rows_lftovr_i,
    input  logic [$clog2(H):0]               cols_lftovr_i,
    input  logic                             h_shift_i,
    output logic [W-1:0][H-1:0][BITW-1:0]    x_buffer_o,
    output logic                             full_o,
    output logic                             empty_o,
    output logic [$clog2(D):0]               count_o,
    output logic                             tile_done_o
);

    localparam int unsigned RW  = $clog2(W) + 1;
    localparam int unsigned HW  = $clog2(H) + 1;
    localparam int unsigned PW  = $clog2(D);
    localparam int unsigned CW  = PW + 1;
    localparam int unsigned HQW = (H > 1) ? $clog2(H) : 1;

    logic [W-1:0][H-1:0][BITW-1:0] slot_q [D];
    logic [W-1:0][H-1:0][BITW-1:0] x_buf_q;

    logic [PW-1:0]  wr_q, rd_q;
    logic [CW-1:0]  count_q;
    logic [RW-1:0]  row_q;
    logic [HQW-1:0] h_q;
    logic           tile_done_q;

    logic [RW-1:0]  row_lim_d;
    logic [HW-1:0]  col_lim_d;
    logic           first_beat;
    logic           accept;
    logic           commit;
    logic           shift;
    logic           free;

    function automatic logic [BITW-1:0] mask_elem(input logic [BITW-1:0] e,
                                                  input int unsigned      h,
                                                  input logic [HW-1:0]    lim);
        return (HW'(h) < lim) ? e : '0;
    endfunction

    assign full_o      = (count_q == CW'(D));
    assign empty_o     = (count_q == '0);
    assign x_ready_o   = !full_o;
    assign count_o     = count_q;
    assign tile_done_o = tile_done_q;
    assign x_buffer_o  = x_buf_q;

    logic unused_x;
    assign unused_x = ^x_i;

    assign first_beat = (row_q == '0);
    assign accept     = x_valid_i && x_ready_o && !clear_i;
    assign commit     = accept && (row_q == row_lim_d - RW'(1));
    assign shift      = h_shift_i && !empty_o && !clear_i;
    assign free       = shift && (h_q == HQW'(H - 1));

`ifdef REDMULE_XBUF_LFTOVR_EN
    logic [RW-1:0] row_lim_q;
    logic [HW-1:0] col_lim_q;
    logic [RW-1:0] row_lim_new;
    logic [HW-1:0] col_lim_new;

    // Limits come straight from the inputs on the first beat so row 0 is masked with them too.
    assign row_lim_new = (rows_lftovr_i != '0) ? rows_lftovr_i : RW'(W);
    assign col_lim_new = (cols_lftovr_i != '0) ? cols_lftovr_i : HW'(H);
    assign row_lim_d   = first_beat ? row_lim_new : row_lim_q;
    assign col_lim_d   = first_beat ? col_lim_new : col_lim_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            row_lim_q <= RW'(W);
            col_lim_q <= HW'(H);
        end else if (clear_i) begin
            row_lim_q <= RW'(W);
            col_lim_q <= HW'(H);
        end else if (accept && first_beat) begin
            row_lim_q <= row_lim_new;
            col_lim_q <= col_lim_new;
        end
    end
`else
    logic unused_lftovr;
    assign unused_lftovr = ^{rows_lftovr_i, cols_lftovr_i};
    assign row_lim_d     = RW'(W);
    assign col_lim_d     = HW'(H);
`endif

    // Queue control: pointers, fill count, row/column progress
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q        <= '0;
            rd_q        <= '0;
            count_q     <= '0;
            row_q       <= '0;
            h_q         <= '0;
            tile_done_q <= 1'b0;
        end else if (clear_i) begin
            wr_q        <= '0;
            rd_q        <= '0;
            count_q     <= '0;
            row_q       <= '0;
            h_q         <= '0;
            tile_done_q <= 1'b0;
        end else begin
            if (accept) begin
                row_q <= commit ? '0 : row_q + RW'(1);
            end
            if (commit) begin
                wr_q <= wr_q + PW'(1);
            end
            if (shift) begin
                h_q <= free ? '0 : h_q + HQW'(1);
            end
            if (free) begin
                rd_q <= rd_q + PW'(1);
            end
            count_q     <= count_q + CW'(commit) - CW'(free);
            tile_done_q <= free;
        end
    end

    // Tile storage write stage; the full flag keeps the occupied head slot out of reach
    always_ff @(posedge clk_i) begin
        for (int w = 0; w < W; w++) begin
            for (int h = 0; h < H; h++) begin
                if (accept) begin
                    if (RW'(w) == row_q) begin
                        slot_q[wr_q][w][h] <= mask_elem(x_i[h*BITW +: BITW], h, col_lim_d);
                    end
`ifdef REDMULE_XBUF_LFTOVR_EN
                    else if (first_beat) begin
                        slot_q[wr_q][w][h] <= '0;
                    end
`endif
                end
            end
        end
    end

    // Output stage: one head-tile column per shift
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_buf_q <= '0;
        end else if (clear_i) begin
            x_buf_q <= '0;
        end else if (shift) begin
            for (int w = 0; w < W; w++) begin
                for (int h = 0; h < H; h++) begin
                    if (HQW'(h) == h_q) begin
                        x_buf_q[w][h] <= slot_q[rd_q][w][h];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_redmule_x_buffer_mq.sv
// Directed self-checking bench for redmule_x_buffer_mq (default parameters).
module tb_redmule_x_buffer_mq;

    localparam int DW   = 288;
    localparam int BITW = 16;
    localparam int H    = 4;
    localparam int W    = 12;
    localparam int D    = 4;

`ifdef REDMULE_XBUF_LFTOVR_EN
    localparam logic [15:0] MASKED = 16'h0000;
`else
    localparam logic [15:0] MASKED = 16'hFFFF;
`endif

    logic                          clk;
    logic                          rst_n;
    logic                          clear;
    logic                          x_valid;
    logic                          x_ready;
    logic [DW-1:0]                 x_data;
    logic [$clog2(W):0]            rows_lftovr;
    logic [$clog2(H):0]            cols_lftovr;
    logic                          h_shift;
    logic [W-1:0][H-1:0][BITW-1:0] xbuf;
    logic                          full;
    logic                          empty;
    logic [$clog2(D):0]            count;
    logic                          tile_done;

    int tests_run    = 0;
    int tests_failed = 0;

    redmule_x_buffer_mq #(.DW(DW), .BITW(BITW), .H(H), .W(W), .D(D)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .clear_i       (clear),
        .x_valid_i     (x_valid),
        .x_ready_o     (x_ready),
        .x_i           (x_data),
        .rows_lftovr_i (rows_lftovr),
        .cols_lftovr_i (cols_lftovr),
        .h_shift_i     (h_shift),
        .x_buffer_o    (xbuf),
        .full_o        (full),
        .empty_o       (empty),
        .count_o       (count),
        .tile_done_o   (tile_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk_row(input logic [15:0] base, input logic [15:0] step);
        logic [DW-1:0] r;
        r = '0;
        for (int h = 0; h < H; h++) r[h*BITW +: BITW] = base + 16'(h) * step;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [15:0] base, input logic [15:0] step);
        x_valid = 1'b1;
        x_data  = mk_row(base, step);
        tick();
        x_valid = 1'b0;
    endtask

    task automatic do_shift();
        h_shift = 1'b1;
        tick();
        h_shift = 1'b0;
    endtask

    task automatic shift_tile();
        for (int s = 0; s < H; s++) do_shift();
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; x_valid = 1'b0; x_data = '0;
        rows_lftovr = '0; cols_lftovr = '0; h_shift = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_xbuf", 64'(|xbuf), 64'd0);
        check("rst_full", 64'(full), 64'd0);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_count", 64'(count), 64'd0);
        check("rst_ready", 64'(x_ready), 64'd1);
        check("rst_done", 64'(tile_done), 64'd0);
        rst_n = 1'b1;
        tick();

        // single tile, no leftovers
        for (int r = 0; r < W; r++) begin
            send_beat(16'h0100 + 16'(r * 4), 16'd1);
            if (r == W - 2) check("t1_count_pre", 64'(count), 64'd0);
        end
        check("t1_count", 64'(count), 64'd1);
        check("t1_empty", 64'(empty), 64'd0);
        for (int s = 0; s < 3; s++) do_shift();
        check("t1_x52", 64'(xbuf[5][2]), 64'h0116);
        check("t1_done3", 64'(tile_done), 64'd0);
        do_shift();
        check("t1_done4", 64'(tile_done), 64'd1);
        check("t1_count0", 64'(count), 64'd0);
        check("t1_x113", 64'(xbuf[11][3]), 64'h012F);
        tick();
        check("t1_done_pulse", 64'(tile_done), 64'd0);

        // fill to depth
        for (int t = 0; t < D; t++)
            for (int r = 0; r < W; r++)
                send_beat(16'hA000 + 16'(t * 256 + r * 16), 16'd1);
        check("fill_full", 64'(full), 64'd1);
        check("fill_ready", 64'(x_ready), 64'd0);
        check("fill_count", 64'(count), 64'd4);
        send_beat(16'hDEAD, 16'd0);
        check("fill_49_count", 64'(count), 64'd4);

        // backpressure release
        for (int s = 0; s < 3; s++) do_shift();
        check("bp_ready3", 64'(x_ready), 64'd0);
        do_shift();
        check("bp_done", 64'(tile_done), 64'd1);
        check("bp_ready", 64'(x_ready), 64'd1);
        check("bp_count", 64'(count), 64'd3);
        check("bp_x00", 64'(xbuf[0][0]), 64'hA000);
        check("bp_x113", 64'(xbuf[11][3]), 64'hA0B3);
        shift_tile();
        check("bp_count2", 64'(count), 64'd2);

        // simultaneous commit and free
        for (int r = 0; r < W - 1; r++) send_beat(16'hB000 + 16'(r * 16), 16'd1);
        for (int s = 0; s < 3; s++) do_shift();
        x_valid = 1'b1;
        x_data  = mk_row(16'hB000 + 16'(11 * 16), 16'd1);
        h_shift = 1'b1;
        tick();
        x_valid = 1'b0;
        h_shift = 1'b0;
        check("sim_count", 64'(count), 64'd2);
        check("sim_done", 64'(tile_done), 64'd1);
        check("sim_x71", 64'(xbuf[7][1]), 64'hA271);
        shift_tile();
        check("sim_rd_x23", 64'(xbuf[2][3]), 64'hA323);
        check("sim_count1", 64'(count), 64'd1);
        shift_tile();
        check("sim_wr_x100", 64'(xbuf[10][0]), 64'hB0A0);
        check("sim_count0", 64'(count), 64'd0);
        check("sim_empty", 64'(empty), 64'd1);

        // leftovers: 5 rows x 3 columns, limits changed after the first beat
        rows_lftovr = 5;
        cols_lftovr = 3;
        send_beat(16'hFFFF, 16'd0);
        rows_lftovr = 0;
        cols_lftovr = 0;
        for (int r = 1; r < 5; r++) send_beat(16'hFFFF, 16'd0);
`ifdef REDMULE_XBUF_LFTOVR_EN
        check("lo_count5", 64'(count), 64'd1);
`else
        check("lo_count5", 64'(count), 64'd0);
        for (int r = 5; r < W; r++) send_beat(16'hFFFF, 16'd0);
        check("lo_count12", 64'(count), 64'd1);
`endif
        shift_tile();
        check("lo_done", 64'(tile_done), 64'd1);
        check("lo_x00", 64'(xbuf[0][0]), 64'hFFFF);
        check("lo_x42", 64'(xbuf[4][2]), 64'hFFFF);
        check("lo_x43", 64'(xbuf[4][3]), 64'(MASKED));
        check("lo_x50", 64'(xbuf[5][0]), 64'(MASKED));
        check("lo_x113", 64'(xbuf[11][3]), 64'(MASKED));

        // shift while empty
        do_shift();
        check("es_x00", 64'(xbuf[0][0]), 64'hFFFF);
        check("es_x50", 64'(xbuf[5][0]), 64'(MASKED));
        check("es_done", 64'(tile_done), 64'd0);
        check("es_count", 64'(count), 64'd0);

        // clear mid-tile, overriding a beat in the same cycle
        for (int r = 0; r < 7; r++) send_beat(16'h5555, 16'd0);
        x_valid = 1'b1;
        x_data  = mk_row(16'h5555, 16'd0);
        clear   = 1'b1;
        tick();
        x_valid = 1'b0;
        clear   = 1'b0;
        check("clr_count", 64'(count), 64'd0);
        check("clr_empty", 64'(empty), 64'd1);
        check("clr_ready", 64'(x_ready), 64'd1);
        check("clr_xbuf", 64'(|xbuf), 64'd0);
        check("clr_done", 64'(tile_done), 64'd0);
        for (int r = 0; r < W - 1; r++) send_beat(16'hC000 + 16'(r * 16), 16'd1);
        check("clr_count11", 64'(count), 64'd0);
        send_beat(16'hC000 + 16'(11 * 16), 16'd1);
        check("clr_count12", 64'(count), 64'd1);
        shift_tile();
        check("clr_x00", 64'(xbuf[0][0]), 64'hC000);
        check("clr_x113", 64'(xbuf[11][3]), 64'hC0B3);
        check("clr_tdone", 64'(tile_done), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/redmule_x_buffer_mq.md
# redmule_x_buffer_mq

Multi-slot X-operand buffer for the RedMulE datapath, sitting between the X streamer and the systolic array inputs. It accepts X rows over a valid/ready stream and packs them into a circular queue of `D` tiles, each `W`×`H` elements, applying leftover masking. It reveals the head tile to the array one column per `h_shift_i` and frees the slot once the last column has been revealed. It replaces the fixed two-deep pad buffer with a parametrised queue depth and a real backpressure handshake.

## Interface
- `DW`, 288: input beat width in bits; must be ≥ `H*BITW`.
- `BITW`, 16: element width in bits.
- `H`, 4: PEs per row, i.e. tile columns.
- `W`, 12: array rows, i.e. tile rows.
- `D`, 4: number of tile slots; a power of two, ≥ 2.
- `clk_i` in 1: the only clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `clear_i` in 1: synchronous soft clear.
- `x_valid_i` in 1: input beat valid.
- `x_ready_o` out 1: input beat ready.
- `x_i` in `DW`: one tile row; element `h` is at `x_i[h*BITW +: BITW]`; upper bits are ignored.
- `rows_lftovr_i` in `$clog2(W)+1`: valid rows in the tile; 0 means `W`.
- `cols_lftovr_i` in `$clog2(H)+1`: valid columns in the tile; 0 means `H`.
- `h_shift_i` in 1: reveal the next column of the head tile.
- `x_buffer_o` out `[W-1:0][H-1:0][BITW]`: registered tile presented to the array.
- `full_o` out 1: `count == D`.
- `empty_o` out 1: `count == 0`.
- `count_o` out `$clog2(D)+1`: number of committed tiles.
- `tile_done_o` out 1: one-cycle pulse when the head slot is freed.

## Operation
- **Storage**
  - `slot[D][W][H]` array.
  - Write pointer `wr_q` and read pointer `rd_q`, each `$clog2(D)` bits, wrapping modulo `D`.
  - Row counter `row_q` and column counter `h_q`.
- **Accept rule**
  - `x_ready_o = !full_o`, driven only from registers.
  - A beat is accepted when `x_valid_i && x_ready_o`.
- **First beat of a tile** (`row_q == 0`)
  - Latch `row_lim_q = rows_lftovr_i ? rows_lftovr_i : W`.
  - Latch `col_lim_q` the same way, from `cols_lftovr_i` with `H` as the default.
  - Zero all `W` rows of `slot[wr_q]`.
  - Row 0 is then written in the same cycle, overriding the zeroing.
- **Every accepted beat**
  - Write `slot[wr_q][row_q][h] = (h < col_lim_q) ? x_i element h : 0`.
  - Increment `row_q`.
- **Commit**: on the beat with `row_q == row_lim_q-1`:
  - Set `row_q` to 0.
  - Increment `wr_q`.
  - Increment `count`.
- **Reveal** (`h_shift_i` while `count != 0`)
  - For every `w`: `x_buffer_o[w][h_q] <= slot[rd_q][w][h_q]`.
  - Increment `h_q`.
  - When `h_q == H-1`: set `h_q` to 0, increment `rd_q`, decrement `count`, and pulse `tile_done_o`.
- `h_shift_i` while `count == 0` is ignored: no state changes and no pulse.
- A commit and a free in the same cycle leave `count` unchanged. Both pointers still advance.
- A slot is never written while it is the occupied head slot, because `full` blocks acceptance.

## Timing
- **Reset values**
  - `x_buffer_o` = 0, `full_o` = 0, `empty_o` = 1, `count_o` = 0, `x_ready_o` = 1, `tile_done_o` = 0.
  - All pointers and counters are 0.
- **Clear**: `clear_i` produces the same state as reset at the next edge.
  - It overrides any accept or shift in the same cycle.
  - Slot contents are don't-care after clear.
- **Latencies**
  - An accepted beat is stored at the next edge.
  - On a commit, `count_o`, `empty_o` and `full_o` update at that same edge.
  - The head tile can be revealed starting the cycle after commit.
  - `x_buffer_o` changes one edge after `h_shift_i`.
- **Backpressure**
  - When the beat that makes `count == D` is accepted, `x_ready_o` drops the next cycle.
  - A free raises `x_ready_o` the cycle after the `tile_done_o` edge; there is no same-cycle bypass.
- **Leftover inputs**
  - `rows_lftovr_i` and `cols_lftovr_i` are sampled only on the first beat of a tile.
  - Changes to them mid-tile have no effect on that tile.
- **Reset mid-tile**: asynchronous reset in the middle of a tile discards the partial tile. `row_q` returns to 0.

## Configuration
- `REDMULE_XBUF_LFTOVR_EN` defined:
  - Leftover masking is active as described above.
  - `rows_lftovr_i` and `cols_lftovr_i` are honoured.
- `REDMULE_XBUF_LFTOVR_EN` undefined:
  - `row_lim_q` is fixed to `W` and `col_lim_q` is fixed to `H`.
  - `rows_lftovr_i` and `cols_lftovr_i` are ignored.
  - The zeroing of row data is removed.
  - Every tile needs exactly `W` beats, and all `H` elements of each beat are stored.

## Test plan
- **Single tile, no leftovers**: send 12 beats, row `r` carrying elements `16'h0100+r*4+h`, then 4 `h_shift_i`.
  - `count_o` reads 1 after beat 12.
  - `x_buffer_o[5][2]` = `16'h0116` after the 3rd shift.
  - `tile_done_o` pulses on the 4th shift.
  - `count_o` then reads 0.
- **Fill to depth**: stream 48 beats continuously with no shifts.
  - `full_o` = 1 and `x_ready_o` = 0 after beat 48.
  - A 49th valid beat is not accepted.
- **Backpressure release**: from full, issue 4 shifts.
  - `x_ready_o` = 1 the cycle after the `tile_done_o` edge.
  - `count_o` reads 3.
- **Leftovers**: `rows_lftovr_i=5`, `cols_lftovr_i=3`, send 5 beats of `16'hFFFF`, then 4 shifts.
  - Rows 0–4 hold `16'hFFFF` in columns 0–2 and 0 in column 3.
  - Rows 5–11 hold 0.
  - Run both with and without `REDMULE_XBUF_LFTOVR_EN`; without it, the tile commits only after 12 beats.
- **Simultaneous commit and free**: with `count_o`=2, the final beat of tile 3 and the 4th shift of the head tile land in the same cycle.
  - `count_o` stays 2.
  - `wr_q` and `rd_q` both advance.
- **Shift while empty, then clear mid-tile**
  - `h_shift_i` with `count_o`=0 leaves `x_buffer_o` unchanged and gives no `tile_done_o` pulse.
  - Asserting `clear_i` after 7 beats gives `count_o`=0, with the next tile starting at row 0.
